ex_muldiv_seq: RTL and testbench

- Iterative RV32M multiply/divide sequencer attached to the EX stage, beside the single-cycle ALU.
- Accepts an M-extension operation from EX and holds the pipeline via `stall` while it runs.
- Produces the result in DWIDTH+2 cycles, or in 1 cycle on the divide special-case fast path.
- The controller FSM sequences a one-bit-per-cycle shift/add (multiply) and shift/subtract (divide) datapath.

---
 rtl/ex_muldiv_pkg.sv | 41 ++++
 rtl/ex_muldiv_dp.sv | 130 +++++++++++++
 rtl/ex_muldiv_seq.sv | 137 +++++++++++++
 tb/tb_ex_muldiv_seq.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ex_muldiv_pkg.sv
// ex_muldiv_pkg
// Shared definitions for the EX-stage RV32M multiply/divide sequencer:
// M-extension funct3 encodings, controller state encodings and small
// decode helpers for operand signedness.
package ex_muldiv_pkg;

    // M-extension funct3 encodings
    localparam logic [2:0] FNC_MUL    = 3'b000;
    localparam logic [2:0] FNC_MULH   = 3'b001;
    localparam logic [2:0] FNC_MULHSU = 3'b010;
    localparam logic [2:0] FNC_MULHU  = 3'b011;
    localparam logic [2:0] FNC_DIV    = 3'b100;
    localparam logic [2:0] FNC_DIVU   = 3'b101;
    localparam logic [2:0] FNC_REM    = 3'b110;
    localparam logic [2:0] FNC_REMU   = 3'b111;

    // Controller states
    typedef enum logic [1:0] {
        EXMD_IDLE  = 2'd0,
        EXMD_CALC  = 2'd1,
        EXMD_FIXUP = 2'd2,
        EXMD_DONE  = 2'd3
    } exmd_state_e;

    // rs1 is signed for everything except the fully unsigned ops.
    function automatic logic op_a_is_signed(input logic [2:0] func);
        return (func != FNC_MULHU) && (func != FNC_DIVU) && (func != FNC_REMU);
    endfunction

    // rs2 is signed only for MUL/MULH/DIV/REM (MULHSU treats it as unsigned).
    function automatic logic op_b_is_signed(input logic [2:0] func);
        return (func == FNC_MUL) || (func == FNC_MULH) ||
               (func == FNC_DIV) || (func == FNC_REM);
    endfunction

    // funct3[2] separates the divide group from the multiply group.
    function automatic logic is_div_op(input logic [2:0] func);
        return func[2];
    endfunction

endpackage

// File: rtl/ex_muldiv_dp.sv
// ex_muldiv_dp
// Datapath for the iterative multiply/divide unit. Works on operand
// magnitudes; signs are reapplied in the fixup step.
//   clk, rst_n   : clock, asynchronous active-low reset
//   load         : latch func, sign flags and operand magnitudes
//   step         : one iteration (shift-add for multiply, restoring
//                  shift-subtract for divide)
//   fixup        : apply sign correction and load the selected result
//   fast_load    : load fast_value straight into the result register
//   func         : funct3 of the operation being loaded
//   op_a, op_b   : raw operands (only used with load)
//   fast_value   : precomputed special-case divide result
//   result       : registered result
module ex_muldiv_dp
    import ex_muldiv_pkg::*;
#(
    parameter int DWIDTH = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              step,
    input  logic              fixup,
    input  logic              fast_load,
    input  logic [2:0]        func,
    input  logic [DWIDTH-1:0] op_a,
    input  logic [DWIDTH-1:0] op_b,
    input  logic [DWIDTH-1:0] fast_value,
    output logic [DWIDTH-1:0] result
);

    logic [2:0]          func_q, func_d;
    logic                neg_q, neg_d;          // signs differ: negate product/quotient
    logic                neg_rem_q, neg_rem_d;  // dividend negative: negate remainder
    logic [DWIDTH-1:0]   mag_b_q, mag_b_d;      // multiplicand / divisor magnitude
    logic [DWIDTH:0]     hi_q, hi_d;            // product high half / partial remainder
    logic [DWIDTH-1:0]   lo_q, lo_d;            // multiplier->product low / dividend->quotient
    logic [DWIDTH-1:0]   result_q, result_d;

    logic                a_neg, b_neg;
    logic [DWIDTH-1:0]   mag_a, mag_b;
    logic [DWIDTH:0]     sum_mul;
    logic [DWIDTH:0]     shifted;
    logic                div_ge;
    logic [2*DWIDTH-1:0] prod, prod_fix;
    logic [DWIDTH-1:0]   rem_mag, quo_fix, rem_fix, fix_sel;

    always_comb begin
        a_neg = op_a_is_signed(func) & op_a[DWIDTH-1];
        b_neg = op_b_is_signed(func) & op_b[DWIDTH-1];
        mag_a = a_neg ? -op_a : op_a;
        mag_b = b_neg ? -op_b : op_b;

        // Multiply: conditionally add multiplicand into the high half,
        // then shift the whole 2*DWIDTH+1 accumulator right by one.
        sum_mul = lo_q[0] ? (hi_q + {1'b0, mag_b_q}) : hi_q;

        // Divide: shift the next dividend bit into the partial remainder
        // and subtract the divisor if it fits.
        shifted = {hi_q[DWIDTH-1:0], lo_q[DWIDTH-1]};
        div_ge  = (shifted >= {1'b0, mag_b_q});

        prod     = {hi_q[DWIDTH-1:0], lo_q};
        prod_fix = neg_q ? -prod : prod;
        rem_mag  = hi_q[DWIDTH-1:0];
        quo_fix  = neg_q ? -lo_q : lo_q;
        rem_fix  = neg_rem_q ? -rem_mag : rem_mag;

        case (func_q)
            FNC_MUL:                          fix_sel = prod_fix[DWIDTH-1:0];
            FNC_MULH, FNC_MULHSU, FNC_MULHU:  fix_sel = prod_fix[2*DWIDTH-1:DWIDTH];
            FNC_DIV, FNC_DIVU:                fix_sel = quo_fix;
            default:                          fix_sel = rem_fix;
        endcase

        func_d    = func_q;
        neg_d     = neg_q;
        neg_rem_d = neg_rem_q;
        mag_b_d   = mag_b_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        result_d  = result_q;

        if (load) begin
            func_d    = func;
            neg_d     = a_neg ^ b_neg;
            neg_rem_d = a_neg;
            mag_b_d   = mag_b;
            hi_d      = '0;
            lo_d      = mag_a;
        end else if (step) begin
            if (is_div_op(func_q)) begin
                hi_d = div_ge ? (shifted - {1'b0, mag_b_q}) : shifted;
                lo_d = {lo_q[DWIDTH-2:0], div_ge};
            end else begin
                hi_d = {1'b0, sum_mul[DWIDTH:1]};
                lo_d = {sum_mul[0], lo_q[DWIDTH-1:1]};
            end
        end

        if (fast_load) begin
            result_d = fast_value;
        end else if (fixup) begin
            result_d = fix_sel;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            func_q    <= '0;
            neg_q     <= 1'b0;
            neg_rem_q <= 1'b0;
            mag_b_q   <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            result_q  <= '0;
        end else begin
            func_q    <= func_d;
            neg_q     <= neg_d;
            neg_rem_q <= neg_rem_d;
            mag_b_q   <= mag_b_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            result_q  <= result_d;
        end
    end

    assign result = result_q;

endmodule

// File: rtl/ex_muldiv_seq.sv
// ex_muldiv_seq
// Iterative RV32M multiply/divide sequencer beside the EX-stage ALU.
// Holds the pipeline with stall while an operation runs; result is valid
// DWIDTH+2 cycles after acceptance, or 1 cycle for divide special cases.
//   clk, rst_n   : clock, asynchronous active-low reset
//   start        : level request from EX, held until result_valid
//   func         : funct3 of the M-extension op
//   op_a, op_b   : forwarded rs1/rs2, sampled at acceptance only
//   flush        : kill the in-flight operation
//   stall        : start & ~result_valid (combinational)
//   busy         : controller not idle
//   result       : registered result, meaningful only with result_valid
//   result_valid : one-cycle pulse
module ex_muldiv_seq
    import ex_muldiv_pkg::*;
#(
    parameter int DWIDTH = 32,
    parameter int CNT_W  = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [2:0]        func,
    input  logic [DWIDTH-1:0] op_a,
    input  logic [DWIDTH-1:0] op_b,
    input  logic              flush,
    output logic              stall,
    output logic              busy,
    output logic [DWIDTH-1:0] result,
    output logic              result_valid
);

    localparam logic [DWIDTH-1:0] SIGNED_MIN = {1'b1, {(DWIDTH-1){1'b0}}};
    localparam logic [CNT_W-1:0]  LAST_ITER  = CNT_W'(DWIDTH - 1);

    exmd_state_e       state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              result_valid_q, result_valid_d;

    logic              dp_load, dp_step, dp_fixup, dp_fast_load;
    logic              op_b_zero, div_ovf, fast_path;
    logic [DWIDTH-1:0] fast_value;

    // Divide special cases resolved without iterating: divide by zero and
    // signed MIN / -1 overflow. funct3[1] selects the remainder variants.
    always_comb begin
        op_b_zero  = (op_b == '0);
        div_ovf    = ((func == FNC_DIV) || (func == FNC_REM)) &&
                     (op_a == SIGNED_MIN) && (op_b == '1);
        fast_path  = is_div_op(func) && (op_b_zero || div_ovf);
        if (op_b_zero) begin
            fast_value = func[1] ? op_a : '1;
        end else begin
            fast_value = func[1] ? '0 : op_a;
        end
    end

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        result_valid_d = 1'b0;
        dp_load        = 1'b0;
        dp_step        = 1'b0;
        dp_fixup       = 1'b0;
        dp_fast_load   = 1'b0;

        if (flush) begin
            // Flush wins over everything, including a same-cycle start.
            state_d = EXMD_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                EXMD_IDLE: begin
                    if (start) begin
                        if (fast_path) begin
                            dp_fast_load   = 1'b1;
                            result_valid_d = 1'b1;
                            state_d        = EXMD_DONE;
                        end else begin
                            dp_load = 1'b1;
                            cnt_d   = '0;
                            state_d = EXMD_CALC;
                        end
                    end
                end
                EXMD_CALC: begin
                    dp_step = 1'b1;
                    if (cnt_q == LAST_ITER) begin
                        state_d = EXMD_FIXUP;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                EXMD_FIXUP: begin
                    dp_fixup       = 1'b1;
                    result_valid_d = 1'b1;
                    state_d        = EXMD_DONE;
                end
                // A start still high in DONE belongs to the retiring op.
                default: state_d = EXMD_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= EXMD_IDLE;
            cnt_q          <= '0;
            result_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            result_valid_q <= result_valid_d;
        end
    end

    ex_muldiv_dp #(
        .DWIDTH(DWIDTH)
    ) u_dp (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (dp_load),
        .step       (dp_step),
        .fixup      (dp_fixup),
        .fast_load  (dp_fast_load),
        .func       (func),
        .op_a       (op_a),
        .op_b       (op_b),
        .fast_value (fast_value),
        .result     (result)
    );

    assign busy         = (state_q != EXMD_IDLE);
    assign result_valid = result_valid_q;
    assign stall        = start & ~result_valid_q;

endmodule

// File: tb/tb_ex_muldiv_seq.sv
// tb_ex_muldiv_seq
// Self-checking bench for ex_muldiv_seq: a reference model derived from
// the RV32M arithmetic rules and the documented latencies is compared
// against busy/stall/result_valid/result every cycle, plus directed
// literal cases and randomized operations with occasional flushes.
`timescale 1ns/1ps
module tb_ex_muldiv_seq;
    import ex_muldiv_pkg::*;

    localparam int DW = 32;
    localparam logic [DW-1:0] MINV = 32'h8000_0000;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          start = 1'b0;
    logic          flush = 1'b0;
    logic [2:0]    func = 3'b000;
    logic [DW-1:0] op_a = '0;
    logic [DW-1:0] op_b = '0;
    logic          stall, busy, result_valid;
    logic [DW-1:0] result;

    int checks = 0;
    int failures = 0;
    bit mon_en = 1'b0;

    always #5 clk = ~clk;

    ex_muldiv_seq #(.DWIDTH(DW), .CNT_W(6)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .func         (func),
        .op_a         (op_a),
        .op_b         (op_b),
        .flush        (flush),
        .stall        (stall),
        .busy         (busy),
        .result       (result),
        .result_valid (result_valid)
    );

    // ---------------- reference arithmetic ----------------
    function automatic logic [DW-1:0] ref_result(input logic [2:0] f,
                                                 input logic [DW-1:0] a,
                                                 input logic [DW-1:0] b);
        longint ax, bx, p;
        logic [63:0] pu;
        int ia, ib;
        if (!f[2]) begin
            ax = (f == FNC_MULHU) ? longint'({32'h0, a}) : longint'($signed(a));
            bx = (f == FNC_MUL || f == FNC_MULH) ? longint'($signed(b)) : longint'({32'h0, b});
            p  = ax * bx;
            pu = p;
            return (f == FNC_MUL) ? pu[31:0] : pu[63:32];
        end
        if (b == 0) return f[1] ? a : 32'hFFFF_FFFF;
        if (!f[0]) begin
            if (a == MINV && b == 32'hFFFF_FFFF) return f[1] ? 32'h0 : MINV;
            ia = $signed(a);
            ib = $signed(b);
            return f[1] ? DW'(ia % ib) : DW'(ia / ib);
        end
        return f[1] ? (a % b) : (a / b);
    endfunction

    function automatic int ref_latency(input logic [2:0] f,
                                       input logic [DW-1:0] a,
                                       input logic [DW-1:0] b);
        if (f[2] && (b == 0 || (!f[0] && a == MINV && b == 32'hFFFF_FFFF))) return 1;
        return DW + 2;
    endfunction

    // ---------------- cycle-level model ----------------
    // m_left counts cycles until the valid cycle; m_valid is the valid cycle.
    int            m_left = 0;
    bit            m_valid = 1'b0;
    logic [DW-1:0] m_result = '0;
    logic [DW-1:0] m_pending = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_left  <= 0;
            m_valid <= 1'b0;
        end else begin
            m_valid <= 1'b0;
            if (flush) begin
                m_left <= 0;
            end else if (m_left == 0 && !m_valid && start) begin
                if (ref_latency(func, op_a, op_b) == 1) begin
                    m_valid  <= 1'b1;
                    m_result <= ref_result(func, op_a, op_b);
                end else begin
                    m_left    <= ref_latency(func, op_a, op_b) - 1;
                    m_pending <= ref_result(func, op_a, op_b);
                end
            end else if (m_left > 0) begin
                if (m_left == 1) begin
                    m_valid  <= 1'b1;
                    m_result <= m_pending;
                end
                m_left <= m_left - 1;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            chk("busy", {31'b0, busy}, {31'b0, (m_left != 0) || m_valid});
            chk("result_valid", {31'b0, result_valid}, {31'b0, m_valid});
            chk("stall", {31'b0, stall}, {31'b0, start && !m_valid});
            if (m_valid) chk("result", result, m_result);
        end
    end

    // ---------------- driver ----------------
    // Entered and left at posedge+1. Cycle 0 is the cycle start is raised.
    task automatic run_op(input logic [2:0] f, input logic [DW-1:0] a, input logic [DW-1:0] b,
                          input int flush_at, output logic [DW-1:0] res, output int lat);
        int cyc;
        bit done;
        cyc  = 0;
        done = 1'b0;
        lat  = -1;
        res  = '0;
        start = 1'b1;
        func  = f;
        op_a  = a;
        op_b  = b;
        while (!done && cyc < 100) begin
            flush = (cyc == flush_at);
            @(negedge clk);
            if (result_valid) begin
                done = 1'b1;
                res  = result;
                lat  = cyc;
            end else if (flush) begin
                done = 1'b1;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL timeout func=%0d a=%h b=%h", f, a, b);
        end
        start = 1'b0;
        flush = 1'b0;
    endtask

    task automatic run_check(input string name, input logic [2:0] f,
                             input logic [DW-1:0] a, input logic [DW-1:0] b,
                             input logic [DW-1:0] exp_res, input int exp_lat, input int flush_at);
        logic [DW-1:0] res;
        int lat;
        run_op(f, a, b, flush_at, res, lat);
        chk({name, "_latency"}, lat, exp_lat);
        if (exp_lat >= 0) chk({name, "_result"}, res, exp_res);
        $display("op %s func=%0d a=%h b=%h result=%h latency=%0d", name, f, a, b, res, lat);
    endtask

    function automatic logic [DW-1:0] pick_operand();
        case ($urandom_range(0, 5))
            0: return '0;
            1: return 32'hFFFF_FFFF;
            2: return MINV;
            3: return DW'($urandom_range(0, 15));
            default: return DW'($urandom);
        endcase
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0]    rf;
        logic [DW-1:0] ra, rb, rexp;
        int            rfl, rlat;

        #2;
        rst_n  = 1'b0;
        mon_en = 1'b1;
        #1;
        chk("reset_busy", {31'b0, busy}, 32'd0);
        chk("reset_valid", {31'b0, result_valid}, 32'd0);
        chk("reset_result", result, 32'd0);
        start = 1'b1;
        #1;
        chk("reset_stall_follows_start", {31'b0, stall}, 32'd1);
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed cases with hand-computed results
        run_check("mul_7_x_m3", FNC_MUL, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 34, -1);
        run_check("mulh_min_min", FNC_MULH, MINV, MINV, 32'h4000_0000, 34, -1);
        run_check("mulhu_max_max", FNC_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34, -1);
        run_check("mulhsu_m1_2", FNC_MULHSU, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 34, -1);
        run_check("div_m7_2", FNC_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34, -1);
        run_check("rem_m7_2", FNC_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34, -1);
        run_check("divu_100_7", FNC_DIVU, 32'd100, 32'd7, 32'd14, 34, -1);
        run_check("remu_100_7", FNC_REMU, 32'd100, 32'd7, 32'd2, 34, -1);
        run_check("fast_divu_5_0", FNC_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, -1);
        run_check("fast_rem_5_0", FNC_REM, 32'd5, 32'd0, 32'd5, 1, -1);
        run_check("fast_div_ovf", FNC_DIV, MINV, 32'hFFFF_FFFF, MINV, 1, -1);
        run_check("fast_rem_ovf", FNC_REM, MINV, 32'hFFFF_FFFF, 32'd0, 1, -1);
        run_check("div_min_2", FNC_DIV, MINV, 32'd2, 32'hC000_0000, 34, -1);

        // Flush at cycle 10 kills the MUL; DIVU starts at cycle 11
        run_check("mul_flushed", FNC_MUL, 32'd123, 32'd456, 32'd0, -1, 10);
        run_check("divu_after_flush", FNC_DIVU, 32'd9, 32'd3, 32'd3, 34, -1);

        // Randomized operations, occasional flush
        for (int i = 0; i < 60; i++) begin
            rf   = 3'($urandom_range(0, 7));
            ra   = pick_operand();
            rb   = pick_operand();
            rexp = ref_result(rf, ra, rb);
            rlat = ref_latency(rf, ra, rb);
            rfl  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 36)) : -1;
            if (rfl >= 0 && rfl < rlat) rlat = -1;
            run_check($sformatf("rand%0d", i), rf, ra, rb, rexp, rlat, rfl);
        end

        // Reset in the middle of CALC
        run_check("divu_pre_reset", FNC_DIVU, 32'd100, 32'd7, 32'd14, 34, -1);
        start = 1'b1;
        func  = FNC_MUL;
        op_a  = 32'h0000_1234;
        op_b  = 32'h0000_5678;
        repeat (17) begin
            @(posedge clk);
            #1;
        end
        chk("pre_reset_busy", {31'b0, busy}, 32'd1);
        rst_n = 1'b0;
        start = 1'b0;
        #1;
        chk("async_reset_busy", {31'b0, busy}, 32'd0);
        chk("async_reset_valid", {31'b0, result_valid}, 32'd0);
        chk("async_reset_result", result, 32'd0);
        $display("op async_reset busy=%0b result_valid=%0b result=%h", busy, result_valid, result);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        run_check("mul_after_reset", FNC_MUL, 32'd3, 32'd4, 32'd12, 34, -1);

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
